// File: rtl/prim_esc_pkg.sv
// Escalation lane encodings shared by the sequencer and the escalation receivers,
// plus the sequencer state type.
package prim_esc_pkg;

  typedef struct packed {
    logic esc_p;
    logic esc_n;
  } esc_tx_t;

  localparam esc_tx_t ESC_TX_DEFAULT = '{esc_p: 1'b0, esc_n: 1'b1};
  localparam esc_tx_t ESC_TX_ACTIVE  = '{esc_p: 1'b1, esc_n: 1'b0};

  typedef enum logic [1:0] {
    SEQ_IDLE     = 2'd0,
    SEQ_PHASE    = 2'd1,
    SEQ_TERMINAL = 2'd2
  } esc_seq_state_e;

endpackage

// File: rtl/esc_phase_cnt.sv
// Loadable down-counter that times one escalation phase.
// The count saturates at zero.
module esc_phase_cnt #(
  parameter int CntW = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic [CntW-1:0] val_i,
  output logic            zero_o
);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CntW'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/esc_phase_seq.sv
// Escalation phase sequencer: asserts escalation lanes cumulatively, one timed phase at a time.
// Define ESC_PHASE_SEQ_LOCK_EN to make TERMINAL sticky until reset.
//
// state        | meaning
// SEQ_IDLE     | all lanes deasserted, waiting for en_i
// SEQ_PHASE    | lanes 0..idx asserted, phase counter running
// SEQ_TERMINAL | all lanes asserted until cleared
module esc_phase_seq
  import prim_esc_pkg::*;
#(
  parameter  int NumPhases = 3,
  parameter  int CntW      = 16,
  localparam int PhW       = $clog2(NumPhases + 1)
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            en_i,
  input  logic                            clr_i,
  input  logic [NumPhases-1:0][CntW-1:0]  phase_cyc_i,
  output esc_tx_t [NumPhases-1:0]         esc_tx_o,
  output logic [PhW-1:0]                  phase_o,
  output logic                            esc_active_o,
  output logic                            done_o
);

  esc_seq_state_e       state_q, state_d;
  logic [PhW-1:0]       idx_q, idx_d;
  logic [NumPhases-1:0] mask_q, mask_d;
  logic [PhW-1:0]       phase_q, phase_d;
  logic                 active_q, active_d;
  logic                 done_q, done_d;
  logic                 cnt_load, cnt_zero;
  logic [CntW-1:0]      cyc_sel, cnt_val;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= SEQ_IDLE;
      idx_q    <= '0;
      mask_q   <= '0;
      phase_q  <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      mask_q   <= mask_d;
      phase_q  <= phase_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_load = 1'b0;
    unique case (state_q)
      SEQ_IDLE: begin
        if (en_i) begin
          state_d  = SEQ_PHASE;
          idx_d    = '0;
          cnt_load = 1'b1;
        end
      end
      SEQ_PHASE: begin
        if (cnt_zero) begin
          if (idx_q == PhW'(NumPhases - 1)) begin
            state_d = SEQ_TERMINAL;
          end else begin
            idx_d    = idx_q + PhW'(1);
            cnt_load = 1'b1;
          end
        end
      end
      SEQ_TERMINAL: ;
      default: begin
        state_d = SEQ_IDLE;
        idx_d   = '0;
      end
    endcase

    // Clear outranks both the trigger and a pending phase advance.
`ifdef ESC_PHASE_SEQ_LOCK_EN
    if (clr_i && (state_q != SEQ_TERMINAL)) begin
`else
    if (clr_i) begin
`endif
      state_d  = SEQ_IDLE;
      idx_d    = '0;
      cnt_load = 1'b0;
    end
  end

  // Duration of the phase being entered; 0 behaves as a single cycle.
  always_comb begin
    cyc_sel = '0;
    for (int k = 0; k < NumPhases; k++) begin
      if (idx_d == PhW'(k)) cyc_sel = phase_cyc_i[k];
    end
    cnt_val = (cyc_sel == '0) ? '0 : cyc_sel - CntW'(1);
  end

  esc_phase_cnt #(
    .CntW (CntW)
  ) u_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (cnt_load),
    .val_i  (cnt_val),
    .zero_o (cnt_zero)
  );

  always_comb begin
    mask_d   = '0;
    phase_d  = '0;
    active_d = 1'b0;
    done_d   = 1'b0;
    unique case (state_d)
      SEQ_PHASE: begin
        for (int k = 0; k < NumPhases; k++) begin
          mask_d[k] = (PhW'(k) <= idx_d);
        end
        phase_d  = idx_d + PhW'(1);
        active_d = 1'b1;
      end
      SEQ_TERMINAL: begin
        mask_d   = '1;
        phase_d  = PhW'(NumPhases);
        active_d = 1'b1;
        done_d   = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    for (int k = 0; k < NumPhases; k++) begin
      esc_tx_o[k] = mask_q[k] ? ESC_TX_ACTIVE : ESC_TX_DEFAULT;
    end
  end

  assign phase_o      = phase_q;
  assign esc_active_o = active_q;
  assign done_o       = done_q;

endmodule
